// File: rtl/ptr_req_arbiter_if.sv
// ptr_req_arbiter_if: requester handshakes and pointer-manager command bus of the arbiter
interface ptr_req_arbiter_if #(parameter int NPORT = 4);
  logic [NPORT-1:0] alloc_req, alloc_gnt, free_req, free_ack;
  logic [9:0] alloc_ptr, ptr_dout_s;
  logic [16*NPORT-1:0] free_head, free_tail;
  logic FQ_rd, FQ_wr, FQ_empty;
  logic [15:0] FQ_din_head, FQ_din_tail;
  modport slave (
    input alloc_req, free_req, free_head, free_tail, FQ_empty, ptr_dout_s,
    output alloc_gnt, alloc_ptr, free_ack, FQ_rd, FQ_wr, FQ_din_head, FQ_din_tail
  );
  modport master (
    output alloc_req, free_req, free_head, free_tail, FQ_empty, ptr_dout_s,
    input alloc_gnt, alloc_ptr, free_ack, FQ_rd, FQ_wr, FQ_din_head, FQ_din_tail
  );
endinterface

// File: rtl/ptr_req_arbiter.sv
// ptr_req_arbiter: round-robin alloc/free arbitration in front of a free-pointer manager
module ptr_req_arbiter #(
  parameter int NPORT = 4,
  parameter int INIT_CYCLES = 520
) (
  input  logic clk,
  input  logic rstn,
  ptr_req_arbiter_if.slave bus,
  output logic init_done,
  output logic [15:0] empty_stall_cnt
);
  localparam int PW = NPORT > 1 ? $clog2(NPORT) : 1;
  localparam int CW = $clog2(INIT_CYCLES + 1);
  typedef enum logic [1:0] {A_IDLE, A_ISSUE, A_WAIT} a_state_t;
  typedef enum logic [1:0] {F_IDLE, F_ISSUE, F_WAIT} f_state_t;
  a_state_t a_state, a_next;
  f_state_t f_state, f_next;
  logic [CW-1:0] init_cnt;
  logic [PW-1:0] a_rr, f_rr, a_win, f_win;
  logic a_go, f_go, a_stall;
  // first requesting port at or after start, wrapping around
  function automatic logic [PW-1:0] rr_pick(input logic [NPORT-1:0] req, input logic [PW-1:0] start);
    rr_pick = start;
    for (int k = NPORT - 1; k >= 0; k--)
      if (req[(int'(start) + k) % NPORT]) rr_pick = PW'((int'(start) + k) % NPORT);
  endfunction
  always_comb begin
    a_win = rr_pick(bus.alloc_req, a_rr);
    f_win = rr_pick(bus.free_req, f_rr);
    a_go = a_state == A_IDLE && init_done && |bus.alloc_req && !bus.FQ_empty;
    f_go = f_state == F_IDLE && init_done && |bus.free_req;
    a_stall = a_state == A_IDLE && init_done && |bus.alloc_req && bus.FQ_empty;
    a_next = a_state == A_IDLE ? (a_go ? A_ISSUE : A_IDLE) : a_state == A_ISSUE ? A_WAIT : A_IDLE;
    f_next = f_state == F_IDLE ? (f_go ? F_ISSUE : F_IDLE) : f_state == F_ISSUE ? F_WAIT : F_IDLE;
  end
  assign bus.FQ_rd = a_state == A_ISSUE;
  assign bus.FQ_wr = f_state == F_ISSUE;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      a_state <= A_IDLE;
      f_state <= F_IDLE;
      a_rr <= '0;
      f_rr <= '0;
      init_cnt <= '0;
      init_done <= 1'b0;
      bus.alloc_gnt <= '0;
      bus.free_ack <= '0;
      bus.alloc_ptr <= '0;
      bus.FQ_din_head <= '0;
      bus.FQ_din_tail <= '0;
      empty_stall_cnt <= '0;
    end else begin
      a_state <= a_next;
      f_state <= f_next;
      if (!init_done) begin
        init_cnt <= init_cnt + 1'b1;
        init_done <= init_cnt == CW'(INIT_CYCLES - 1);
      end
      bus.alloc_gnt <= a_go ? NPORT'(1) << a_win : '0;
      bus.free_ack <= f_go ? NPORT'(1) << f_win : '0;
      if (a_go) begin
        bus.alloc_ptr <= bus.ptr_dout_s;
        a_rr <= PW'((int'(a_win) + 1) % NPORT);
      end
      if (f_go) begin
        bus.FQ_din_head <= bus.free_head[16*f_win +: 16];
        bus.FQ_din_tail <= bus.free_tail[16*f_win +: 16];
        f_rr <= PW'((int'(f_win) + 1) % NPORT);
      end
      if (a_stall && empty_stall_cnt != 16'hFFFF) empty_stall_cnt <= empty_stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_ptr_req_arbiter.sv
// tb_ptr_req_arbiter: directed scenario checks of the pointer request arbiter
module tb_ptr_req_arbiter;
  localparam int INIT = 520;
  logic clk = 1'b0, rstn = 1'b0, init_done;
  logic [15:0] empty_stall_cnt;
  int errors = 0, checks = 0;
  ptr_req_arbiter_if #(.NPORT(4)) bus();
  ptr_req_arbiter #(.NPORT(4), .INIT_CYCLES(INIT)) dut (
    .clk(clk), .rstn(rstn), .bus(bus.slave), .init_done(init_done), .empty_stall_cnt(empty_stall_cnt)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input int req_at, input logic [3:0] req_val);
    int n = 0, bad = 0;
    while (n < INIT + 20) begin
      tick;
      n++;
      if (n == req_at) bus.alloc_req = req_val;
      if (init_done) break;
      if (bus.FQ_rd || bus.FQ_wr || bus.alloc_gnt != 0 || bus.free_ack != 0) bad++;
    end
    checks++;
    if (n !== INIT) begin errors++; $display("FAIL init_latency: got %0d cycles expected %0d", n, INIT); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL cmd_before_init: got %0d active cycles expected 0", bad); end
    checks++;
    if (bus.FQ_rd !== 1'b0 || bus.alloc_gnt !== 4'b0) begin
      errors++; $display("FAIL gnt_at_init_done: got rd=%b gnt=%b expected 0/0000", bus.FQ_rd, bus.alloc_gnt);
    end
  endtask

  task automatic test_reset;
    bus.alloc_req = '0; bus.free_req = '0; bus.free_head = '0; bus.free_tail = '0;
    bus.FQ_empty = 1'b0; bus.ptr_dout_s = '0; rstn = 1'b0;
    tick; tick;
    checks++;
    if ({bus.FQ_rd, bus.FQ_wr, bus.alloc_gnt, bus.free_ack, init_done} !== 11'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0", {bus.FQ_rd, bus.FQ_wr, bus.alloc_gnt, bus.free_ack, init_done});
    end
    checks++;
    if ({bus.alloc_ptr, bus.FQ_din_head, bus.FQ_din_tail, empty_stall_cnt} !== 58'b0) begin
      errors++; $display("FAIL reset_data: got ptr=%h head=%h tail=%h stall=%0d expected 0", bus.alloc_ptr, bus.FQ_din_head, bus.FQ_din_tail, empty_stall_cnt);
    end
  endtask

  task automatic test_init;
    rstn = 1'b1;
    bus.ptr_dout_s = 10'h3A5;
    wait_init(100, 4'b0001);
    tick;
    checks++;
    if (bus.alloc_gnt !== 4'b0001 || bus.FQ_rd !== 1'b1 || bus.alloc_ptr !== 10'h3A5) begin
      errors++; $display("FAIL first_gnt: got gnt=%b rd=%b ptr=%h expected 0001/1/3a5", bus.alloc_gnt, bus.FQ_rd, bus.alloc_ptr);
    end
    bus.alloc_req = '0;
    tick;
    checks++;
    if (bus.alloc_gnt !== 4'b0 || bus.FQ_rd !== 1'b0) begin
      errors++; $display("FAIL wait_state: got gnt=%b rd=%b expected 0000/0", bus.alloc_gnt, bus.FQ_rd);
    end
    tick;
  endtask

  task automatic test_round_robin;
    logic [9:0] p = '0, last = '0;
    logic [3:0] eg;
    rstn = 1'b0; tick; rstn = 1'b1;
    bus.ptr_dout_s = '0;
    wait_init(1, 4'b1111);
    for (int c = 0; c < 15; c++) begin
      tick;
      eg = (c % 3 == 0) ? 4'b0001 << ((c / 3) % 4) : 4'b0;
      if (eg != 0) last = p;
      checks++;
      if (bus.alloc_gnt !== eg) begin errors++; $display("FAIL rr_gnt c=%0d: got %b expected %b", c, bus.alloc_gnt, eg); end
      checks++;
      if (bus.FQ_rd !== (eg != 0)) begin errors++; $display("FAIL rr_rd c=%0d: got %b expected %b", c, bus.FQ_rd, eg != 0); end
      checks++;
      if (bus.alloc_ptr !== last) begin errors++; $display("FAIL rr_ptr c=%0d: got %h expected %h", c, bus.alloc_ptr, last); end
      p = p + 10'd37;
      bus.ptr_dout_s = p;
    end
    bus.alloc_req = '0;
  endtask

  task automatic test_empty_stall;
    int bad = 0;
    bus.FQ_empty = 1'b1;
    bus.alloc_req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (bus.alloc_gnt != 0 || bus.FQ_rd) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL gnt_while_empty: got %0d active cycles expected 0", bad); end
    checks++;
    if (empty_stall_cnt !== 16'd10) begin errors++; $display("FAIL stall_cnt: got %0d expected 10", empty_stall_cnt); end
    bus.free_req = 4'b0100;
    bus.free_head = '0; bus.free_head[47:32] = 16'h0005;
    bus.free_tail = '0; bus.free_tail[47:32] = 16'h0007;
    tick;
    checks++;
    if (bus.FQ_wr !== 1'b1 || bus.free_ack !== 4'b0100 || bus.FQ_din_head !== 16'h0005 || bus.FQ_din_tail !== 16'h0007) begin
      errors++; $display("FAIL free_while_empty: got wr=%b ack=%b head=%h tail=%h expected 1/0100/0005/0007", bus.FQ_wr, bus.free_ack, bus.FQ_din_head, bus.FQ_din_tail);
    end
    bus.FQ_empty = 1'b0;
    bus.free_req = '0;
    tick;
    checks++;
    if (bus.alloc_gnt !== 4'b0100 || bus.FQ_rd !== 1'b1) begin
      errors++; $display("FAIL gnt_after_free: got gnt=%b rd=%b expected 0100/1", bus.alloc_gnt, bus.FQ_rd);
    end
    checks++;
    if (empty_stall_cnt !== 16'd11) begin errors++; $display("FAIL stall_cnt_final: got %0d expected 11", empty_stall_cnt); end
    bus.alloc_req = '0;
    tick;
    checks++;
    if (bus.FQ_wr !== 1'b0 || bus.FQ_din_head !== 16'h0005 || bus.FQ_din_tail !== 16'h0007) begin
      errors++; $display("FAIL din_hold: got wr=%b head=%h tail=%h expected 0/0005/0007", bus.FQ_wr, bus.FQ_din_head, bus.FQ_din_tail);
    end
  endtask

  task automatic test_concurrent;
    tick; tick;
    bus.alloc_req = 4'b0010;
    bus.free_req = 4'b1000;
    bus.free_head = '0; bus.free_head[63:48] = 16'hBEEF;
    bus.free_tail = '0; bus.free_tail[63:48] = 16'h1234;
    bus.ptr_dout_s = 10'h155;
    tick;
    checks++;
    if (bus.FQ_rd !== 1'b1 || bus.FQ_wr !== 1'b1 || bus.alloc_gnt !== 4'b0010 || bus.free_ack !== 4'b1000) begin
      errors++; $display("FAIL concurrent_cmd: got rd=%b wr=%b gnt=%b ack=%b expected 1/1/0010/1000", bus.FQ_rd, bus.FQ_wr, bus.alloc_gnt, bus.free_ack);
    end
    checks++;
    if (bus.alloc_ptr !== 10'h155 || bus.FQ_din_head !== 16'hBEEF || bus.FQ_din_tail !== 16'h1234) begin
      errors++; $display("FAIL concurrent_data: got ptr=%h head=%h tail=%h expected 155/beef/1234", bus.alloc_ptr, bus.FQ_din_head, bus.FQ_din_tail);
    end
    bus.alloc_req = '0;
    bus.free_req = '0;
    tick;
  endtask

  task automatic test_reset_mid_issue;
    tick; tick;
    bus.alloc_req = 4'b0110;
    tick;
    checks++;
    if (bus.alloc_gnt !== 4'b0100 || bus.FQ_rd !== 1'b1) begin
      errors++; $display("FAIL pre_reset_gnt: got gnt=%b rd=%b expected 0100/1", bus.alloc_gnt, bus.FQ_rd);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({bus.FQ_rd, bus.FQ_wr, bus.alloc_gnt, bus.free_ack, init_done} !== 11'b0) begin
      errors++; $display("FAIL async_reset_ctrl: got %b expected 0", {bus.FQ_rd, bus.FQ_wr, bus.alloc_gnt, bus.free_ack, init_done});
    end
    checks++;
    if ({bus.alloc_ptr, bus.FQ_din_head, bus.FQ_din_tail, empty_stall_cnt} !== 58'b0) begin
      errors++; $display("FAIL async_reset_data: got ptr=%h head=%h tail=%h stall=%0d expected 0", bus.alloc_ptr, bus.FQ_din_head, bus.FQ_din_tail, empty_stall_cnt);
    end
    tick; tick;
    rstn = 1'b1;
    wait_init(1, 4'b0110);
    tick;
    checks++;
    if (bus.alloc_gnt !== 4'b0010 || bus.FQ_rd !== 1'b1) begin
      errors++; $display("FAIL post_reset_rr: got gnt=%b rd=%b expected 0010/1", bus.alloc_gnt, bus.FQ_rd);
    end
    bus.alloc_req = '0;
    tick;
  endtask

  initial begin
    test_reset;
    test_init;
    test_round_robin;
    test_empty_stall;
    test_concurrent;
    test_reset_mid_issue;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ptr_req_arbiter.md
PTR_REQ_ARBITER -- requirements
Module: ptr_req_arbiter

Interface
REQ-001 Parameter NPORT, 4, number of alloc requesters and of free requesters.
REQ-002 Parameter INIT_CYCLES, 520, cycles after reset release before the pointer manager accepts commands (covers its 512-entry list fill).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 alloc_req  input  NPORT  per-port level request for one free cell pointer.
REQ-006 alloc_gnt  output  NPORT  one-hot, one-cycle grant pulse.
REQ-007 alloc_ptr  output  10  pointer delivered with alloc_gnt.
REQ-008 free_req  input  NPORT  per-port level request to return a pointer chain.
REQ-009 free_head  input  16*NPORT  per-port chain head; port i at bits [16i+15:16i].
REQ-010 free_tail  input  16*NPORT  per-port chain tail, same packing.
REQ-011 free_ack  output  NPORT  one-hot, one-cycle acceptance pulse.
REQ-012 FQ_rd  output  1  read command to the pointer manager.
REQ-013 FQ_empty  input  1  free queue empty from the pointer manager.
REQ-014 ptr_dout_s  input  10  current free-queue head pointer.
REQ-015 FQ_wr  output  1  write command to the pointer manager.
REQ-016 FQ_din_head, FQ_din_tail  output  16 each  chain head/tail with FQ_wr.
REQ-017 init_done  output  1  high once INIT_CYCLES elapsed.
REQ-018 empty_stall_cnt  output  16  saturating count of cycles an alloc was blocked by FQ_empty.

Function
REQ-019 Init counter SHALL count from 0 after reset release; init_done SHALL rise on the cycle the count reaches INIT_CYCLES and stay high; no grant or ack SHALL issue while init_done is low.
REQ-020 Alloc FSM SHALL have states A_IDLE, A_ISSUE, A_WAIT; free FSM SHALL have states F_IDLE, F_ISSUE, F_WAIT; the two run independently and MAY issue in the same cycle.
REQ-021 A_IDLE -> A_ISSUE when init_done, |alloc_req and !FQ_empty; winner chosen round-robin starting at the port after the last granted port (port 0 first after reset).
REQ-022 On that transition the block SHALL register FQ_rd=1, alloc_gnt[winner]=1 and alloc_ptr=ptr_dout_s, all visible together for exactly one cycle (A_ISSUE).
REQ-023 A_ISSUE -> A_WAIT -> A_IDLE unconditionally; FQ_rd and alloc_gnt SHALL be 0 in A_WAIT; peak rate one alloc per 3 cycles.
REQ-024 alloc_ptr SHALL hold its last value between grants.
REQ-025 Free FSM SHALL mirror REQ-021..023 using free_req, independent round-robin pointer, FQ_wr/free_ack, with FQ_din_head/FQ_din_tail registered from the winner's free_head/free_tail; FQ_empty SHALL NOT block frees.
REQ-026 FQ_din_head/FQ_din_tail SHALL hold last values when FQ_wr is low.
REQ-027 A requester SHALL keep req high until its gnt/ack; a req still high the cycle after its pulse is a new request.
REQ-028 empty_stall_cnt SHALL increment in each A_IDLE cycle with init_done, |alloc_req and FQ_empty, saturating at 16'hFFFF.
REQ-029 Round-robin pointer SHALL update only on a grant/ack; a port deasserting req before service SHALL simply be skipped.

Reset
REQ-030 On rstn low, asynchronously: both FSMs idle, RR pointers to port 0, init counter 0, init_done 0, FQ_rd 0, FQ_wr 0, alloc_gnt 0, free_ack 0, alloc_ptr 0, FQ_din_head/tail 0, empty_stall_cnt 0.
REQ-031 Reset asserted mid-ISSUE SHALL drop FQ_rd/FQ_wr and pulses immediately; no command SHALL re-issue after release before init_done.

Verification
REQ-032 alloc_req=4'b1111 held at init_done, ptr_dout_s=0 -> grants ports 0,1,2,3,0 at 3-cycle spacing, FQ_rd coincident with each gnt, alloc_ptr equals ptr_dout_s sampled one cycle before.
REQ-033 alloc_req=4'b0001 during init count 100 -> no FQ_rd until init_done, first gnt the cycle after init_done.
REQ-034 FQ_empty=1, alloc_req=4'b0100 for 10 cycles -> no gnt, empty_stall_cnt=10; then free_req[2] with head=0x0005, tail=0x0007 -> FQ_wr with those values, FQ_empty drops, gnt[2] follows.
REQ-035 alloc_req=4'b0010 and free_req=4'b1000 same cycle -> FQ_rd and FQ_wr asserted in the same cycle, gnt[1] and ack[3] together.
REQ-036 rstn low during A_ISSUE -> FQ_rd and alloc_gnt 0 immediately, init_done 0, all REQ-030 values.
